apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have port pclk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port preset, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port transfer, input, 1, command request from the local side.
REQ-004 SHALL have ports cmd_write (input, 1, 1=write), cmd_addr (input, 9, target address) and cmd_wdata (input, 32, write data).
REQ-005 SHALL have port cmd_ready, output, 1, command acceptance.
REQ-006 SHALL have ports paddr (output, 9), psel (output, 1), penable (output, 1), pwrite (output, 1) and pwdata (output, 32): APB requester outputs.
REQ-007 SHALL have ports pready (input, 1) and prdata (input, 32): completer responses.
REQ-008 SHALL have ports rsp_valid (output, 1, one-cycle completion pulse), rsp_rdata (output, 32, read data) and rsp_timeout (output, 1, aborted-transfer flag).

Function
REQ-009 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-010 SHALL accept a command on a rising edge where transfer=1 and cmd_ready=1, and latch cmd_write/cmd_addr/cmd_wdata.
REQ-011 SHALL drive cmd_ready=1 in IDLE and in the ACCESS cycle where pready=1; otherwise 0.
REQ-012 SHALL transition IDLE->SETUP on accept; outputs in SETUP: psel=1, penable=0, paddr/pwrite/pwdata=latched values.
REQ-013 SHALL always transition SETUP->ACCESS after exactly one cycle; outputs in ACCESS: psel=1, penable=1.
REQ-014 SHALL hold paddr/pwrite/pwdata stable from SETUP through the end of ACCESS.
REQ-015 SHALL stay in ACCESS while pready=0 (wait states).
REQ-016 SHALL, in ACCESS with pready=1, go to SETUP if a new command is accepted in that cycle (back-to-back, no IDLE gap), else to IDLE.
REQ-017 SHALL drive psel=0, penable=0 in IDLE.
REQ-018 SHALL pulse rsp_valid=1 for exactly one cycle, in the cycle after the completion edge.
REQ-019 SHALL, with that pulse, drive rsp_rdata=prdata captured at completion for reads and 32'h0 for writes.
REQ-020 SHALL hold rsp_rdata at its last value outside rsp_valid pulses.
REQ-021 SHALL give minimum latency of accept edge T -> SETUP T+1 -> ACCESS T+2 -> rsp_valid at T+3 (zero wait states).
REQ-022 SHALL ignore transfer when cmd_ready=0, with no queuing.

Reset
REQ-023 SHALL, while preset=1 at a rising edge, force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0 and rsp_timeout=0.
REQ-024 SHALL, on reset asserted mid-transfer (SETUP or ACCESS), drop psel/penable at that edge and never issue rsp_valid for the aborted transfer.
REQ-025 SHALL drive cmd_ready=0 while preset=1.

Configuration
REQ-026 SHALL, with macro APB_MASTER_TIMEOUT_EN defined, count consecutive ACCESS cycles with pready=0.
REQ-027 SHALL, when that count reaches TIMEOUT_CYCLES (package constant, 16), abort at that edge: go to IDLE, psel=0, penable=0, rsp_valid=1 with rsp_timeout=1 and rsp_rdata=0 in the following cycle.
REQ-028 SHALL clear the counter on entry to each SETUP; rsp_timeout=0 for normal completions.
REQ-029 SHALL, without the macro, wait indefinitely in ACCESS; rsp_timeout port present and tied 0.

Structure
REQ-030 SHALL place ADDR_W=9, DATA_W=32, TIMEOUT_CYCLES=16 and enum apb_state_e {IDLE, SETUP, ACCESS} in shared package apb_pkg.
REQ-031 SHALL place the timeout counter in sub-module apb_master_wdog (inputs clear, count_en; output expired), instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-032 SHALL cover single write: addr 9'h04, wdata 32'hDEADBEEF, pready=1 -> psel at T+1, penable at T+2, rsp_valid at T+3, rsp_rdata=0.
REQ-033 SHALL cover read with 3 wait states: addr 9'h1FF, prdata 32'hCAFEF00D on pready -> ACCESS lasts 4 cycles with stable paddr; rsp_rdata=32'hCAFEF00D.
REQ-034 SHALL cover back-to-back: write 9'h010 then read 9'h020 with transfer held -> second SETUP immediately after first ACCESS; psel never drops.
REQ-035 SHALL cover reset mid-ACCESS: preset=1 during a wait state -> psel=penable=0 next edge, no rsp_valid.
REQ-036 SHALL cover timeout (macro on): pready held 0 -> abort after 16 ACCESS cycles, rsp_valid=1, rsp_timeout=1; (macro off) -> psel held indefinitely.
REQ-037 SHALL cover ignored command: transfer=1 during SETUP -> not accepted; paddr unchanged.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB master definitions: bus widths, watchdog limit and FSM states.
// Optional feature macro used by apb_master: APB_MASTER_TIMEOUT_EN.
package apb_pkg;

  localparam int ADDR_W         = 9;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_master_wdog.sv
// ACCESS wait-state watchdog: counts consecutive stalled ACCESS cycles and
// flags the cycle whose edge would complete the TIMEOUT_CYCLES-th stall.
module apb_master_wdog
  import apb_pkg::*;
(
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // Stall counter, restarted for every new transfer.
  always_ff @(posedge pclk) begin
    if (preset || clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry is seen in the cycle whose rising edge would be the last stall.
  assign expired = count_en && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule : apb_master_wdog

// File: rtl/apb_master.sv
// APB requester: accepts one local command at a time and runs it through
// IDLE -> SETUP -> ACCESS, reporting completion with a one-cycle pulse.
// Define APB_MASTER_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES.
module apb_master
  import apb_pkg::*;
(
  input  logic              pclk,
  input  logic              preset,
  input  logic              transfer,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout
);

  apb_state_e        state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_timeout_q;

  logic accept;
  logic wdog_expired;

  // Ready when idle, or in the completing ACCESS cycle so a new command can
  // follow without an IDLE gap; never ready while reset is held.
  assign cmd_ready = !preset &&
                     ((state_q == IDLE) || ((state_q == ACCESS) && pready));
  assign accept    = transfer && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_wdog u_wdog (
    .pclk     (pclk),
    .preset   (preset),
    .clear    (accept),
    .count_en ((state_q == ACCESS) && !pready),
    .expired  (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  // Protocol FSM with all bus and response outputs registered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            if (accept) begin
              paddr_q   <= cmd_addr;
              pwrite_q  <= cmd_write;
              pwdata_q  <= cmd_wdata;
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              state_q   <= SETUP;
            end else begin
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              state_q   <= IDLE;
            end
          end else if (wdog_expired) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers checked against a transaction-level expectation queue.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        transfer;
  logic        cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_ready;
  logic [8:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;

  int checks = 0;
  int errors = 0;

  // Expected response data for each issued transfer, in issue order.
  logic [31:0] exp_q[$];

  apb_master dut (
    .pclk        (pclk),
    .preset      (preset),
    .transfer    (transfer),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_ready   (cmd_ready),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pready      (pready),
    .prdata      (prdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Response that a completed transfer must report.
  function automatic logic [31:0] rsp_of(input logic w, input logic [31:0] rd);
    return w ? 32'h0 : rd;
  endfunction

  // One isolated transfer from IDLE with a given number of wait states.
  task automatic run_txn(input logic w, input logic [8:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd);
    logic [31:0] exp;
    transfer = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; pready = 1'b0;
    #1 chk("idle_cmd_ready", cmd_ready, 1);
    tick();
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    chk("setup_pwdata", pwdata, d);
    // A command offered during SETUP must be ignored.
    cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
    #1 chk("setup_cmd_ready", cmd_ready, 0);
    tick();
    transfer = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("wait_penable", penable, 1);
      chk("wait_paddr", paddr, a);
      chk("wait_pwdata", pwdata, d);
      chk("wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    chk("access_psel", psel, 1);
    chk("access_penable", penable, 1);
    chk("access_paddr", paddr, a);
    pready = 1'b1; prdata = rd;
    exp_q.push_back(rsp_of(w, rd));
    #1 chk("access_cmd_ready", cmd_ready, 1);
    tick();
    pready = 1'b0; prdata = $urandom;
    exp = exp_q.pop_front();
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_rsp_rdata", rsp_rdata, exp);
    chk("done_rsp_timeout", rsp_timeout, 0);
    chk("done_psel", psel, 0);
    chk("done_penable", penable, 0);
    tick();
    chk("after_rsp_valid", rsp_valid, 0);
    chk("hold_rsp_rdata", rsp_rdata, exp);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] rd;
    preset = 1'b1; transfer = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; pready = 1'b0; prdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    preset = 1'b0;
    tick();

    // Single write, zero wait states
    run_txn(1'b1, 9'h004, 32'hDEADBEEF, 0, 32'h12345678);
    $display("txn single write addr=004 done");

    // Read with three wait states
    run_txn(1'b0, 9'h1FF, 32'h0, 3, 32'hCAFEF00D);
    $display("txn read 3-wait addr=1FF done");

    // Back-to-back write then read, transfer held high
    transfer = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h010; cmd_wdata = 32'hA5A5A5A5;
    tick();
    chk("b2b_setup1_paddr", paddr, 9'h010);
    chk("b2b_setup1_psel", psel, 1);
    cmd_write = 1'b0; cmd_addr = 9'h020; cmd_wdata = 32'h0;
    tick();
    chk("b2b_access1_penable", penable, 1);
    chk("b2b_access1_paddr", paddr, 9'h010);
    pready = 1'b1; prdata = 32'h0BADF00D;
    tick();
    chk("b2b_setup2_psel", psel, 1);
    chk("b2b_setup2_penable", penable, 0);
    chk("b2b_setup2_paddr", paddr, 9'h020);
    chk("b2b_setup2_pwrite", pwrite, 0);
    chk("b2b_rsp1_valid", rsp_valid, 1);
    chk("b2b_rsp1_rdata", rsp_rdata, 32'h0);
    transfer = 1'b0; pready = 1'b0;
    tick();
    chk("b2b_access2_psel", psel, 1);
    chk("b2b_access2_penable", penable, 1);
    chk("b2b_access2_rsp_valid", rsp_valid, 0);
    pready = 1'b1; prdata = 32'h600DCAFE;
    tick();
    pready = 1'b0;
    chk("b2b_rsp2_valid", rsp_valid, 1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h600DCAFE);
    chk("b2b_idle_psel", psel, 0);
    tick();
    $display("txn back-to-back 010/020 done");

    // Reset during an ACCESS wait state
    transfer = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h0AA; pready = 1'b0;
    tick();
    transfer = 1'b0;
    tick();
    tick();
    chk("mid_access_penable", penable, 1);
    preset = 1'b1; pready = 1'b1; prdata = 32'hFFFFFFFF;
    #1 chk("mid_rst_cmd_ready", cmd_ready, 0);
    tick();
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    preset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_psel", psel, 0);
    end
    pready = 1'b0;
    $display("txn reset mid-access done");

    // Stalled transfer: abort with the watchdog, or wait forever without it
    transfer = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h155; pready = 1'b0;
    tick();
    transfer = 1'b0;
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("to_access_penable", penable, 1);
      chk("to_access_rsp_valid", rsp_valid, 0);
      tick();
    end
    chk("to_abort_psel", psel, 0);
    chk("to_abort_penable", penable, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    tick();
    chk("to_after_rsp_valid", rsp_valid, 0);
    chk("to_after_rsp_timeout", rsp_timeout, 0);
    $display("txn timeout abort done");
`else
    for (int i = 0; i < 40; i++) begin
      chk("stall_psel", psel, 1);
      chk("stall_penable", penable, 1);
      chk("stall_rsp_valid", rsp_valid, 0);
      chk("stall_rsp_timeout", rsp_timeout, 0);
      tick();
    end
    do_reset();
    tick();
    $display("txn stall without timeout done");
`endif

    // Randomized isolated transfers
    for (int n = 0; n < 24; n++) begin
      logic        w;
      logic [8:0]  a;
      logic [31:0] d;
      int          waits;
      w     = 1'($urandom_range(0, 1));
      a     = 9'($urandom);
      d     = $urandom;
      rd    = $urandom;
      waits = int'($urandom_range(0, 6));
      run_txn(w, a, d, waits, rd);
      $display("txn rand %0d w=%0d addr=%h waits=%0d", n, w, a, waits);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_apb_master
